// File: rtl/muldiv_pkg.sv
// +--------------------------------------------------------------------------+
// | muldiv_pkg : funct3 encodings, FSM state type and operand signedness     |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   // {a_signed, b_signed}; MUL low half is sign-agnostic so it runs unsigned
   function automatic logic [1:0] operand_signed(input logic [2:0] f3);
      logic [1:0] s;
      case (f3)
         F3_MULH, F3_DIV, F3_REM: s = 2'b11;
         F3_MULHSU:               s = 2'b10;
         default:                 s = 2'b00;
      endcase
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// +--------------------------------------------------------------------------+
// | muldiv_step : one radix-2 shift-add / restoring shift-subtract step      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] mq_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] mq_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
      shifted = {acc_i, mq_i[XLEN-1]};
      diff    = shifted - {1'b0, opnd_i};
      if (is_div_i) begin
         // diff MSB set means the trial subtraction went negative: restore
         acc_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
         mq_o  = {mq_i[XLEN-2:0], ~diff[XLEN]};
      end else begin
         acc_o = sum[XLEN:1];
         mq_o  = {sum[0], mq_i[XLEN-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// +--------------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M/RV64M multiply/divide unit                 |
// | Option      : MULDIV_EARLY_OUT_EN skips CALC for trivial operands        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int             N        = XLEN / BITS_PER_CYCLE;
   localparam int             CW       = $clog2(N + 1);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(N);

   muldiv_state_t   state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      f3_q, f3_d;
   logic [XLEN-1:0] acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d, result_q, result_d;
   logic            neg_q, neg_d;

   logic            accept, a_neg, b_neg, b_zero;
   logic [1:0]      sgn;
   logic [XLEN-1:0] a_mag, b_mag;

   assign accept = in_valid && (state_q == IDLE);
   assign sgn    = operand_signed(funct3);
   assign a_neg  = sgn[1] & a[XLEN-1];
   assign b_neg  = sgn[0] & b[XLEN-1];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;
   assign b_zero = (b == '0);

   logic [XLEN-1:0] acc_ch [BITS_PER_CYCLE+1];
   logic [XLEN-1:0] mq_ch  [BITS_PER_CYCLE+1];

   assign acc_ch[0] = acc_q;
   assign mq_ch[0]  = mq_q;

   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
         .is_div_i (f3_q[2]),
         .acc_i    (acc_ch[i]),
         .mq_i     (mq_ch[i]),
         .opnd_i   (opnd_q),
         .acc_o    (acc_ch[i+1]),
         .mq_o     (mq_ch[i+1])
      );
   end

   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

   always_comb begin
      prod     = {acc_ch[BITS_PER_CYCLE], mq_ch[BITS_PER_CYCLE]};
      prod_fix = neg_q ? -prod : prod;
      quot_fix = neg_q ? -mq_ch[BITS_PER_CYCLE] : mq_ch[BITS_PER_CYCLE];
      rem_fix  = neg_q ? -acc_ch[BITS_PER_CYCLE] : acc_ch[BITS_PER_CYCLE];
      case (f3_q)
         F3_MUL:                       final_res = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              final_res = quot_fix;
         default:                      final_res = rem_fix;
      endcase
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic            early;
   logic [XLEN-1:0] early_res;

   always_comb begin
      early     = 1'b0;
      early_res = '0;
      if (funct3[2]) begin
         if (b_zero) begin
            early     = 1'b1;
            early_res = funct3[1] ? a : '1;
         end else if (sgn[1] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
            early     = 1'b1;
            early_res = funct3[1] ? '0 : a;
         end
      end else if (a == '0 || b_zero) begin
         early = 1'b1;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      acc_d    = acc_q;
      mq_d     = mq_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               f3_d   = funct3;
               cnt_d  = CNT_LOAD;
               acc_d  = '0;
               mq_d   = funct3[2] ? a_mag : b_mag;
               opnd_d = funct3[2] ? b_mag : a_mag;
               // divide-by-zero quotient must stay all ones, so no negate there
               neg_d  = funct3[2] ? (funct3[1] ? a_neg : (a_neg ^ b_neg) & ~b_zero)
                                  : (a_neg ^ b_neg);
`ifdef MULDIV_EARLY_OUT_EN
               if (early) begin
                  state_d  = DONE;
                  result_d = early_res;
               end else begin
                  state_d  = CALC;
               end
`else
               state_d = CALC;
`endif
            end
         end
         CALC: begin
            acc_d = acc_ch[BITS_PER_CYCLE];
            mq_d  = mq_ch[BITS_PER_CYCLE];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d  = DONE;
               result_d = final_res;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         acc_q    <= '0;
         mq_q     <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         acc_q    <= acc_d;
         mq_q     <= mq_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// +--------------------------------------------------------------------------+
// | tb_muldiv_unit : directed self-checking bench for muldiv_unit (XLEN=32)  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int SP_LAT = 1;
`else
   localparam int SP_LAT = 33;
`endif

   muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct3    (funct3),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // lat counts cycles from the accept cycle to the first cycle out_valid is seen
   task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                         input bit hs, output logic [31:0] res, output int lat,
                         output int rdy_bad);
      int g;
      @(negedge clk);
      funct3 = f; a = av; b = bv; in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; funct3 = 3'($urandom);
      lat = 1; rdy_bad = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_bad++;
         @(posedge clk); #1;
         lat++;
      end
      if (in_ready) rdy_bad++;
      res = result;
      if (hs) begin
         @(negedge clk); out_ready = 1'b1;
         @(posedge clk); #1; out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 00000000", result); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_mul();
      logic [31:0] r; int lat, rb;
      run_op(3'b000, 32'd7, 32'hFFFFFFFD, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mul_7_m3: got %h expected ffffffeb", r); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency: got %0d expected 33", lat); end
      n_vec++; if (rb !== 0) begin n_err++; $display("FAIL mul_in_ready_low: got %0d high cycles expected 0", rb); end
      run_op(3'b000, 32'h12345678, 32'h10, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'h23456780) begin n_err++; $display("FAIL mul_wrap: got %h expected 23456780", r); end
   endtask

   task automatic test_mulh();
      logic [31:0] r; int lat, rb;
      run_op(3'b001, 32'h80000000, 32'h80000000, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'h40000000) begin n_err++; $display("FAIL mulh_min_min: got %h expected 40000000", r); end
      run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mulhu_ones: got %h expected fffffffe", r); end
      run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mulhsu_ones: got %h expected ffffffff", r); end
      run_op(3'b001, 32'hFFFFFFFF, 32'd5, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mulh_m1_5: got %h expected ffffffff", r); end
   endtask

   task automatic test_div();
      logic [31:0] r; int lat, rb;
      run_op(3'b100, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_m7_2: got %h expected fffffffd", r); end
      run_op(3'b110, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rem_m7_2: got %h expected ffffffff", r); end
      run_op(3'b101, 32'd100, 32'd7, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'd14) begin n_err++; $display("FAIL divu_100_7: got %h expected 0000000e", r); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL divu_latency: got %0d expected 33", lat); end
      run_op(3'b111, 32'd100, 32'd7, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL remu_100_7: got %h expected 00000002", r); end
      run_op(3'b100, 32'd7, 32'hFFFFFFFE, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_7_m2: got %h expected fffffffd", r); end
      run_op(3'b110, 32'd7, 32'hFFFFFFFE, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL rem_7_m2: got %h expected 00000001", r); end
   endtask

   task automatic test_special();
      logic [31:0] r; int lat, rb;
      run_op(3'b101, 32'd5, 32'd0, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divu_by0: got %h expected ffffffff", r); end
      n_vec++; if (lat !== SP_LAT) begin n_err++; $display("FAIL divu_by0_latency: got %0d expected %0d", lat, SP_LAT); end
      run_op(3'b110, 32'd5, 32'd0, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'd5) begin n_err++; $display("FAIL rem_by0: got %h expected 00000005", r); end
      n_vec++; if (lat !== SP_LAT) begin n_err++; $display("FAIL rem_by0_latency: got %0d expected %0d", lat, SP_LAT); end
      run_op(3'b100, 32'hFFFFFFFB, 32'd0, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg_by0: got %h expected ffffffff", r); end
      run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'h80000000) begin n_err++; $display("FAIL div_overflow: got %h expected 80000000", r); end
      n_vec++; if (lat !== SP_LAT) begin n_err++; $display("FAIL div_overflow_latency: got %0d expected %0d", lat, SP_LAT); end
      run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL rem_overflow: got %h expected 00000000", r); end
      run_op(3'b000, 32'd0, 32'd5, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL mul_zero: got %h expected 00000000", r); end
      n_vec++; if (lat !== SP_LAT) begin n_err++; $display("FAIL mul_zero_latency: got %0d expected %0d", lat, SP_LAT); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; int lat, rb, bad_res, bad_ov, bad_ir;
      run_op(3'b101, 32'd1000, 32'd10, 1'b0, r, lat, rb);
      n_vec++; if (r !== 32'd100) begin n_err++; $display("FAIL bp_result: got %h expected 00000064", r); end
      bad_res = 0; bad_ov = 0; bad_ir = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (result !== 32'd100) bad_res++;
         if (out_valid !== 1'b1) bad_ov++;
         if (in_ready !== 1'b0) bad_ir++;
      end
      n_vec++; if (bad_res !== 0) begin n_err++; $display("FAIL bp_result_stable: got %0d bad cycles expected 0", bad_res); end
      n_vec++; if (bad_ov !== 0) begin n_err++; $display("FAIL bp_out_valid_held: got %0d bad cycles expected 0", bad_ov); end
      n_vec++; if (bad_ir !== 0) begin n_err++; $display("FAIL bp_in_ready_low: got %0d bad cycles expected 0", bad_ir); end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_hs: got %b expected 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_after_hs: got %b expected 0", out_valid); end
      run_op(3'b111, 32'd1000, 32'd7, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'd6) begin n_err++; $display("FAIL bp_next_op: got %h expected 00000006", r); end
   endtask

   task automatic test_reset_midop();
      logic [31:0] r; int lat, rb;
      @(negedge clk);
      funct3 = 3'b011; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2; rst = 1'b1; #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready); end
      run_op(3'b000, 32'd3, 32'd4, 1'b1, r, lat, rb);
      n_vec++; if (r !== 32'd12) begin n_err++; $display("FAIL rst_then_mul: got %h expected 0000000c", r); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL rst_then_mul_latency: got %0d expected 33", lat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_special();
      test_back_to_back();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative, parametrised multiply/divide unit implementing the RV32M/RV64M operations. It is the multi-cycle companion to the single-cycle ALU and sits beside it in the execute stage. Operands enter through a valid/ready handshake, and results leave through a held valid/ready handshake. The control path stalls issue while in_ready is low.

Parameters:
XLEN, 32, operand/result width; must be 32 or 64.
BITS_PER_CYCLE, 1, radix-2 steps per CALC cycle; must divide XLEN (1, 2, 4).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  unit can accept; high only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  XLEN  rs1 operand (multiplicand/dividend)
b  input  XLEN  rs2 operand (multiplier/divisor)
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  XLEN  registered result
busy  output  1  state != IDLE

Behaviour:
- Reset: the state is forced to IDLE immediately. out_valid=0, result=0, busy=0, in_ready=1, and all internal registers are 0.
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC on in_valid && in_ready. On the same edge, funct3 is latched, operand magnitudes are latched (absolute value for signed operands per op), and the result-sign flag is latched. The step counter is loaded with N = XLEN/BITS_PER_CYCLE.
- CALC: performs BITS_PER_CYCLE shift-add (multiply) or restoring shift-subtract (divide) steps per cycle and decrements the counter. When the counter reaches 1, the state moves to DONE. On that same edge, sign fixup (two's-complement negate if the flag is set) and high/low half select are applied, and result is registered.
- DONE: out_valid=1 and result is held stable until out_ready. On out_valid && out_ready, the state moves to IDLE. in_ready is 0 in DONE, so there is no back-to-back accept. The next accept happens at the earliest one cycle after the handshake.
- Latency: out_valid rises N+1 cycles after the accept edge. For XLEN=32 and BITS_PER_CYCLE=1, that is 33 cycles.
- Multiply: the 2·XLEN product is formed. MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned semantics respectively.
- Divide: truncating division, with the remainder taking the dividend's sign.
- Boundary: divide by zero gives DIV/DIVU = all ones and REM/REMU = a.
- Boundary: signed overflow (a = most negative value, b = −1) gives DIV = a and REM = 0.
- Boundary: these special cases use the full latency unless the optional feature below is enabled.
- Inputs a, b and funct3 are ignored outside the accept cycle. Changes during CALC have no effect.
- Reset mid-operation: the operation is discarded with no output. in_ready is 1 on the first clock edge after rst deasserts.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: divide by zero, signed overflow, and any multiply with a zero operand skip CALC. The state goes IDLE -> DONE on the accept edge with the correct result, so out_valid rises 1 cycle after accept.
- Undefined: every operation takes N+1 cycles. This gives data-independent timing.

Decomposition:
- Package muldiv_pkg holds:
  - localparams for the eight funct3 encodings;
  - typedef enum logic [1:0] muldiv_state_t {IDLE, CALC, DONE};
  - a function giving the per-op signedness of a and b.
- Sub-module muldiv_step is purely combinational and performs one radix-2 multiply or divide step on the accumulator/remainder pair. It is instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (−3), accept at cycle 0 -> out_valid at cycle 33, result=0xFFFFFFEB. in_ready=0 during cycles 1–34.
2. High-half multiplies:
   - MULH 0x80000000×0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed divide and remainder:
   - DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD.
   - REM -> 0xFFFFFFFF.
   - DIVU 100 / 7 -> 14.
   - REMU -> 2.
4. Special cases:
   - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
   - With MULDIV_EARLY_OUT_EN defined, each has out_valid 1 cycle after accept.
5. Backpressure: out_ready held low for 10 cycles in DONE -> result stable, out_valid=1, in_ready=0. After the handshake, a new op is accepted the next cycle and gives the correct result.
6. Reset mid-op: rst asserted at CALC cycle 10 -> out_valid=0, busy=0, in_ready=1 immediately. After release, MUL 3×4 returns 12 with no residue from the aborted op.
